spi_tx_arbiter: RTL and testbench

- Shares one 16-bit SPI transmit channel between `NUM_REQ` requesters.
- Arbitrates pending requests (round-robin by default) and latches the winner's word.
- Serialises the word MSB-first on `spi_cs_l` / `spi_sclk` / `spi_data`, then reports completion.
- Sits between the register/command blocks that produce SPI words and the external SPI slave; it replaces direct per-source drive of the serial pins.

---
 rtl/spi_tx_arbiter_if.sv | 27 ++
 rtl/spi_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_tx_arbiter_if.sv
// Bus bundle between the SPI word producers, the transmit arbiter and the serial pins.
// The master modport is the producer/bench side and the slave modport is the arbiter side.
interface spi_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] datain;
    logic [NUM_REQ-1:0]        grant;
    logic                      done;
    logic [2:0]                done_id;
    logic                      busy;
    logic                      spi_cs_l;
    logic                      spi_sclk;
    logic                      spi_data;
    logic [4:0]                counter;

    modport master (
        output req, datain,
        input  grant, done, done_id, busy, spi_cs_l, spi_sclk, spi_data, counter
    );

    modport slave (
        input  req, datain,
        output grant, done, done_id, busy, spi_cs_l, spi_sclk, spi_data, counter
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Shares one 16-bit MSB-first SPI (mode 0) transmit channel between NUM_REQ requesters.
// Round-robin by default; define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module spi_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int SCLK_HALF = 1
) (
    input  logic            clk,
    input  logic            reset,
    spi_tx_arbiter_if.slave bus
);
    localparam int               DIV_W     = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_HALF - 1);
    localparam logic [4:0]       LAST_HALF = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_STOP
    } state_t;

    state_t              r_state,   w_state;
    logic [DIV_W-1:0]    r_div,     w_div;
    logic [4:0]          r_half,    w_half;
    logic [DATA_W-1:0]   r_shift,   w_shift;
    logic [2:0]          r_owner,   w_owner;
    logic [NUM_REQ-1:0]  r_grant,   w_grant;
    logic                r_done,    w_done;
    logic [2:0]          r_done_id, w_done_id;
    logic                r_busy,    w_busy;
    logic                r_cs_l,    w_cs_l;
    logic                r_sclk,    w_sclk;
    logic [4:0]          r_counter, w_counter;

    logic                w_found;
    logic [2:0]          w_winner;

`ifndef SPI_ARB_FIXED_PRIO_EN
    logic [2:0]          r_last;
    int                  w_bestDist;
`endif

    // Winner selection: the requester closest after the last winner (or the lowest index in fixed mode)
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
`ifdef SPI_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_found  = 1'b1;
                w_winner = 3'(i);
            end
        end
`else
        w_bestDist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && (((i + 2*NUM_REQ - int'(r_last) - 1) % NUM_REQ) < w_bestDist)) begin
                w_found    = 1'b1;
                w_winner   = 3'(i);
                w_bestDist = (i + 2*NUM_REQ - int'(r_last) - 1) % NUM_REQ;
            end
        end
`endif
    end

`ifndef SPI_ARB_FIXED_PRIO_EN
    // Reset to the top index so that requester 0 is the first to win
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 3'(NUM_REQ - 1);
        end else if (r_state == S_IDLE && w_found) begin
            r_last <= w_winner;
        end
    end
`endif

    // Frame sequencer; the data pin is the MSB of the shift register, so a falling edge is just a shift
    always_comb begin
        w_state   = r_state;
        w_div     = r_div;
        w_half    = r_half;
        w_shift   = r_shift;
        w_owner   = r_owner;
        w_grant   = '0;
        w_done    = 1'b0;
        w_done_id = r_done_id;
        w_busy    = r_busy;
        w_cs_l    = r_cs_l;
        w_sclk    = r_sclk;
        w_counter = r_counter;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    for (int j = 0; j < NUM_REQ; j++) begin
                        if (w_winner == 3'(j)) begin
                            w_grant[j] = 1'b1;
                            w_shift    = bus.datain[j*DATA_W +: DATA_W];
                        end
                    end
                    w_owner = w_winner;
                    w_busy  = 1'b1;
                    w_cs_l  = 1'b0;
                    w_div   = '0;
                    w_state = S_START;
                end
            end
            S_START: begin
                if (r_div == DIV_LAST) begin
                    w_div     = '0;
                    w_half    = '0;
                    w_sclk    = 1'b1;
                    w_counter = r_counter + 5'd1;
                    w_state   = S_SHIFT;
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            S_SHIFT: begin
                // Half-period 31 is the low phase after the 16th falling edge
                if (r_div == DIV_LAST) begin
                    w_div = '0;
                    if (r_half == LAST_HALF) begin
                        w_state = S_STOP;
                    end else begin
                        w_half = r_half + 5'd1;
                        if (r_sclk) begin
                            w_sclk  = 1'b0;
                            w_shift = r_shift << 1;
                        end else begin
                            w_sclk    = 1'b1;
                            w_counter = r_counter + 5'd1;
                        end
                    end
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (r_div == DIV_LAST) begin
                    w_div     = '0;
                    w_cs_l    = 1'b1;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_done_id = r_owner;
                    w_counter = '0;
                    w_shift   = '0;
                    w_state   = S_IDLE;
                end else begin
                    w_div = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_half    <= '0;
            r_shift   <= '0;
            r_owner   <= '0;
            r_grant   <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_busy    <= 1'b0;
            r_cs_l    <= 1'b1;
            r_sclk    <= 1'b0;
            r_counter <= '0;
        end else begin
            r_state   <= w_state;
            r_div     <= w_div;
            r_half    <= w_half;
            r_shift   <= w_shift;
            r_owner   <= w_owner;
            r_grant   <= w_grant;
            r_done    <= w_done;
            r_done_id <= w_done_id;
            r_busy    <= w_busy;
            r_cs_l    <= w_cs_l;
            r_sclk    <= w_sclk;
            r_counter <= w_counter;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.done     = r_done;
    assign bus.done_id  = r_done_id;
    assign bus.busy     = r_busy;
    assign bus.spi_cs_l = r_cs_l;
    assign bus.spi_sclk = r_sclk;
    assign bus.spi_data = r_shift[DATA_W-1];
    assign bus.counter  = r_counter;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Randomised scoreboard bench for spi_tx_arbiter: a frame-level model predicts grants and words,
// a monitor decodes the serial pins; a second instance with SCLK_HALF=3 covers the divider.
module tb_spi_tx_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 16;
    localparam int HALF      = 1;
    localparam int FRAME_LOW = 34 * HALF;

    typedef struct {
        int          id;
        logic [15:0] word;
        int          grantCycle;
    } frame_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus  ();
    spi_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus3 ();

    spi_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SCLK_HALF(HALF)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    spi_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SCLK_HALF(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    int                 vectors     = 0;
    int                 miscompares = 0;
    int                 cycle       = 0;
    frame_t             expQ[$];
    frame_t             monFrame;
    frame_t             newFrame;
    int                 modelCount  = 0;
    int                 modelLast   = NUM_REQ - 1;
    logic [NUM_REQ-1:0] reqVec;
    logic [15:0]        words [NUM_REQ];
    int                 mode;
    bit                 grantedNow;
    int                 grantedId;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Arbitration rule written straight from the requester list
    function automatic int pickWinner();
`ifdef SPI_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqVec[i]) return i;
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (reqVec[(modelLast + k) % NUM_REQ]) return (modelLast + k) % NUM_REQ;
        end
`endif
        return 0;
    endfunction

    task automatic driveBus();
        bus.req = reqVec;
        for (int i = 0; i < NUM_REQ; i++) bus.datain[i*DATA_W +: DATA_W] = words[i];
    endtask

    // The channel is unavailable for 34*HALF edges after a grant, then samples req again
    task automatic modelStep();
        grantedNow = 1'b0;
        if (modelCount > 0) begin
            modelCount--;
        end else if (reqVec != '0) begin
            grantedId           = pickWinner();
            newFrame.id         = grantedId;
            newFrame.word       = words[grantedId];
            newFrame.grantCycle = cycle;
            expQ.push_back(newFrame);
            modelLast  = grantedId;
            modelCount = FRAME_LOW;
            grantedNow = 1'b1;
        end
    endtask

    task automatic applyStimulus();
        if (grantedNow) begin
            case (mode)
                0: begin
                    reqVec[grantedId] = 1'b0;
                    words[grantedId]  = 16'h4839;
                end
                1: begin
                end
                2: begin
                    words[grantedId] = 16'($urandom());
                    if ($urandom_range(0, 1) == 0) reqVec[grantedId] = 1'b0;
                end
                default: reqVec[grantedId] = 1'b0;
            endcase
        end
        if (mode == 2) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!reqVec[i] && !(grantedNow && grantedId == i) && $urandom_range(0, 7) == 0) begin
                    reqVec[i] = 1'b1;
                    words[i]  = 16'($urandom());
                end
            end
        end
        driveBus();
    endtask

    task automatic tick();
        @(posedge clk);
        cycle++;
        modelStep();
        @(negedge clk);
        applyStimulus();
    endtask

    // Monitor: decodes frames from the pins and retires them against the scoreboard
    logic        monSclkPrev;
    logic [15:0] monWord;
    int          monRises;
    int          monCsLow;

    always @(negedge clk) begin
        if (reset) begin
            monSclkPrev = 1'b0;
            monWord     = '0;
            monRises    = 0;
            monCsLow    = 0;
        end else begin
            if (bus.grant != '0) begin
                monWord  = '0;
                monRises = 0;
                monCsLow = 0;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedGrant", 32'(bus.grant), 32'd0);
                end else begin
                    checkOutput("grantVector", 32'(bus.grant), 32'd1 << expQ[0].id);
                    checkOutput("grantCycle", cycle, expQ[0].grantCycle);
                    checkOutput("busyAtGrant", 32'(bus.busy), 32'd1);
                end
            end
            if (!bus.spi_cs_l) monCsLow++;
            if (bus.spi_sclk && !monSclkPrev) begin
                monRises++;
                monWord = {monWord[14:0], bus.spi_data};
                checkOutput("counterAtRise", 32'(bus.counter), monRises);
            end
            if (bus.done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'(bus.done), 32'd0);
                end else begin
                    monFrame = expQ.pop_front();
                    checkOutput("doneId", 32'(bus.done_id), monFrame.id);
                    checkOutput("serialWord", 32'(monWord), 32'(monFrame.word));
                    checkOutput("csLowCycles", monCsLow, FRAME_LOW);
                    checkOutput("risingEdges", monRises, 16);
                    checkOutput("csHighAtDone", 32'(bus.spi_cs_l), 32'd1);
                    checkOutput("busyClearAtDone", 32'(bus.busy), 32'd0);
                    checkOutput("counterClearAtDone", 32'(bus.counter), 32'd0);
                end
            end
            monSclkPrev = bus.spi_sclk;
        end
    end

    task automatic runDividerFrame(input logic [15:0] word);
        int          csLow      = 0;
        int          rises      = 0;
        int          firstRise  = 0;
        int          secondRise = 0;
        int          n          = 0;
        logic        prevSclk   = 1'b0;
        logic [15:0] cap        = '0;
        bit          gotGrant   = 1'b0;
        bit          gotDone    = 1'b0;
        @(negedge clk);
        bus3.req    = 4'b0001;
        bus3.datain = {48'h0, word};
        while (!gotDone && n < 300) begin
            @(negedge clk);
            n++;
            if (bus3.grant[0]) begin
                gotGrant = 1'b1;
                bus3.req = '0;
            end
            if (!bus3.spi_cs_l) csLow++;
            if (bus3.spi_sclk && !prevSclk) begin
                rises++;
                cap = {cap[14:0], bus3.spi_data};
                if (rises == 1) firstRise = n;
                if (rises == 2) secondRise = n;
            end
            prevSclk = bus3.spi_sclk;
            if (bus3.done) begin
                gotDone = 1'b1;
                checkOutput("div3DoneId", 32'(bus3.done_id), 32'd0);
            end
        end
        checkOutput("div3Grant", 32'(gotGrant), 32'd1);
        checkOutput("div3Done", 32'(gotDone), 32'd1);
        checkOutput("div3CsLow", csLow, 102);
        checkOutput("div3SclkPeriod", secondRise - firstRise, 6);
        checkOutput("div3Rises", rises, 16);
        checkOutput("div3Word", 32'(cap), 32'(word));
    endtask

    initial begin
        reset      = 1'b1;
        reqVec     = '0;
        mode       = 0;
        grantedNow = 1'b0;
        grantedId  = 0;
        for (int i = 0; i < NUM_REQ; i++) words[i] = '0;
        driveBus();
        bus3.req    = '0;
        bus3.datain = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetGrant", 32'(bus.grant), 32'd0);
        checkOutput("resetDone", 32'(bus.done), 32'd0);
        checkOutput("resetDoneId", 32'(bus.done_id), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetCsL", 32'(bus.spi_cs_l), 32'd1);
        checkOutput("resetSclk", 32'(bus.spi_sclk), 32'd0);
        checkOutput("resetData", 32'(bus.spi_data), 32'd0);
        checkOutput("resetCounter", 32'(bus.counter), 32'd0);
        reset = 1'b0;

        $display("[TB] single frame from requester 0");
        mode      = 0;
        reqVec    = 4'b0001;
        words[0]  = 16'h0412;
        driveBus();
        repeat (45) tick();

        $display("[TB] all requesters held");
        mode   = 1;
        words  = '{16'h0412, 16'h4839, 16'hABEB, 16'h1234};
        reqVec = 4'b1111;
        driveBus();
        repeat (5 * 35 + 5) tick();

        $display("[TB] randomised requests");
        mode   = 2;
        reqVec = '0;
        driveBus();
        repeat (1500) tick();

        $display("[TB] reset in the middle of a frame");
        reqVec[1] = 1'b1;
        driveBus();
        for (int k = 0; k < 300 && modelCount != 15; k++) tick();
        checkOutput("reachMidFrame", modelCount, 15);
        #1 reset = 1'b1;
        #1;
        checkOutput("midResetCsL", 32'(bus.spi_cs_l), 32'd1);
        checkOutput("midResetSclk", 32'(bus.spi_sclk), 32'd0);
        checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
        checkOutput("midResetCounter", 32'(bus.counter), 32'd0);
        checkOutput("midResetData", 32'(bus.spi_data), 32'd0);
        expQ.delete();
        modelCount = 0;
        modelLast  = NUM_REQ - 1;
        repeat (2) @(negedge clk);
        checkOutput("midResetDone", 32'(bus.done), 32'd0);
        reset = 1'b0;
        repeat (300) tick();

        mode   = 3;
        reqVec = '0;
        driveBus();
        for (int k = 0; k < 200 && modelCount != 0; k++) tick();
        repeat (3) tick();
        checkOutput("framesPending", expQ.size(), 32'd0);
        checkOutput("idleBusy", 32'(bus.busy), 32'd0);
        checkOutput("idleCsL", 32'(bus.spi_cs_l), 32'd1);

        $display("[TB] divider instance, SCLK_HALF=3");
        runDividerFrame(16'hFFFF);
        runDividerFrame(16'($urandom()) | 16'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end
endmodule
